unified_mem_arbiter: RTL and testbench

Shares one single-port unified instruction/data memory between the IF stage fetch port and the MEM stage load/store port.
- Runs one transaction at a time through a fixed-latency memory.
- Data port has priority, with a starvation limit that guarantees fetch progress.
- Drives per-stage stall signals that the pipeline uses to gate PCWrite and the pipeline registers.

---
 rtl/unified_mem_arbiter_pkg.sv | 15 +
 rtl/arb_lat_timer.sv | 41 ++++
 rtl/unified_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter.
// Holds the arbiter state encoding and the default bus widths so the
// pipeline top can size its own fetch/load-store ports consistently.
package unified_mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_lat_timer.sv
// Memory latency timer for the unified memory arbiter.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, clears the count
//   load - command issued this cycle; count restarts at MEM_LAT
//   done - current cycle is the one in which read data is valid
module arb_lat_timer #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  localparam int CNT_W = 4;

  logic [CNT_W-1:0] lat_cnt_q;
  logic [CNT_W-1:0] lat_cnt_d;

  // Count parks at zero while idle so a stale value can never raise done.
  always_comb begin
    lat_cnt_d = lat_cnt_q;
    if (load) begin
      lat_cnt_d = CNT_W'(MEM_LAT);
    end else if (lat_cnt_q != '0) begin
      lat_cnt_d = lat_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt_q <= '0;
    end else begin
      lat_cnt_q <= lat_cnt_d;
    end
  end

  assign done = (lat_cnt_q == CNT_W'(1));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port unified memory between the IF fetch port
// and the MEM load/store port. One transaction in flight at a time; data
// port has priority unless fetch has been passed over STARVE_MAX times.
// Ports:
//   if_*    - fetch request/accept/return
//   dm_*    - load/store request/accept/return (dm_rdata is 0 on store ack)
//   mem_*   - command strobe, write enable, address, write data, read data
//   stall_* - per-stage stall requests (combinational)
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  arb_state_t          state_q, state_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                is_store_q, is_store_d;
  logic                issue;
  logic                lat_done;
  logic                if_win;
  logic                dm_win;

  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
    return (v == STARVE_W'(STARVE_MAX)) ? v : v + STARVE_W'(1);
  endfunction

  arb_lat_timer #(
    .MEM_LAT(MEM_LAT)
  ) u_lat_timer (
    .clk (clk),
    .rst (rst),
    .load(issue),
    .done(lat_done)
  );

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    is_store_d   = is_store_q;
    issue        = 1'b0;
    if_win       = 1'b0;
    dm_win       = 1'b0;
    if_ready     = 1'b0;
    if_rvalid    = 1'b0;
    if_rdata     = '0;
    dm_ready     = 1'b0;
    dm_rvalid    = 1'b0;
    dm_rdata     = '0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    // Nothing issues or returns while reset is held: the in-flight
    // response is dropped and the bus stays quiet.
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if_win = if_req & (~dm_req | (starve_cnt_q == STARVE_W'(STARVE_MAX)));
          dm_win = dm_req & ~if_win;
          if (if_win) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
            if_ready = 1'b1;
            issue    = 1'b1;
            state_d  = BUSY_IF;
          end else if (dm_win) begin
            mem_en     = 1'b1;
            mem_we     = dm_we;
            mem_addr   = dm_addr;
            mem_wdata  = dm_wdata;
            dm_ready   = 1'b1;
            issue      = 1'b1;
            is_store_d = dm_we;
            state_d    = BUSY_DM;
          end
          // Every other idle outcome (fetch won, or no fetch waiting)
          // resets the starvation count.
          if (dm_win && if_req) begin
            starve_cnt_d = sat_inc(starve_cnt_q);
          end else begin
            starve_cnt_d = '0;
          end
        end
        BUSY_IF: begin
          if (lat_done) begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
            state_d   = IDLE;
          end
        end
        BUSY_DM: begin
          if (lat_done) begin
            dm_rvalid = 1'b1;
            dm_rdata  = is_store_q ? '0 : mem_rdata;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign stall_if  = if_req & ~if_rvalid;
  assign stall_mem = dm_req & ~dm_rvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      is_store_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      is_store_q   <= is_store_d;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] dm_addr = '0, dm_wdata = '0;
  logic        dm_ready, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_if, stall_mem;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  function automatic logic [31:0] init_word(input int idx);
    if (idx == 4) return 32'h00A00093;
    if (idx == 5) return 32'h00B00113;
    return 32'h1000_0000 + 32'(idx * 4);
  endfunction

  // Memory device: fixed latency LAT, read returns pre-write contents.
  logic [31:0] dev_mem [0:63];
  bit          dev_wr  [0:63];
  logic [31:0] rd_pipe [0:LAT-1];
  assign mem_rdata = rd_pipe[LAT-1];

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      dev_mem[mem_addr[7:2]] <= mem_wdata;
      dev_wr[mem_addr[7:2]]  <= 1'b1;
    end
    rd_pipe[0] <= !mem_en ? 32'h0 :
                  (dev_wr[mem_addr[7:2]] ? dev_mem[mem_addr[7:2]] : init_word(int'(mem_addr[7:2])));
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  typedef struct packed {
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        if_ready;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_ready;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        stall_if;
    logic        stall_mem;
  } outs_t;

  typedef struct {
    logic        r, ir;
    logic [31:0] ia;
    logic        dr, dwe;
    logic [31:0] da, dwd;
    outs_t       exp;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model state: transaction-level view of the arbiter.
  bit          m_busy = 0;
  bit          m_own_if = 0;
  int          m_ret = 0;
  int          m_cyc = 0;
  int          m_starve = 0;
  logic [31:0] m_data = '0;
  logic [31:0] sh_mem [0:63];
  bit          sh_wr  [0:63];

  // Stimulus agents and protocol tracking.
  bit          ip = 0, dp = 0, dwe_a = 0;
  logic [31:0] ia_a = '0, da_a = '0, dwd_a = '0;
  bit          if_acc = 0, dm_acc = 0, if_wait = 0, dm_wait = 0;

  function automatic outs_t act_outs();
    return {mem_en, mem_we, mem_addr, mem_wdata, if_ready, if_rvalid, if_rdata,
            dm_ready, dm_rvalid, dm_rdata, stall_if, stall_mem};
  endfunction

  function automatic outs_t o(input logic men, mwe, input logic [31:0] maddr, mwd,
                              input logic ifr, ifv, input logic [31:0] ifd,
                              input logic dmr, dmv, input logic [31:0] dmd,
                              input logic sif, smem);
    return {men, mwe, maddr, mwd, ifr, ifv, ifd, dmr, dmv, dmd, sif, smem};
  endfunction

  function automatic vec_t mkv(input logic r, ir, input logic [31:0] ia,
                               input logic dr, dwe, input logic [31:0] da, dwd,
                               input outs_t e);
    vec_t v;
    v.r = r; v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd; v.exp = e;
    return v;
  endfunction

  function automatic logic [31:0] sh_read(input logic [31:0] a);
    return sh_wr[a[7:2]] ? sh_mem[a[7:2]] : init_word(int'(a[7:2]));
  endfunction

  task automatic check_outs(input string name, input outs_t a, input outs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, m_cyc, a, e);
    end
  endtask

  task automatic check_int(input string name, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, a, e);
    end
  endtask

  // Expected outputs for the inputs now on the pins, then advance one cycle.
  task automatic model_step(output outs_t e);
    bit iw, dw;
    e = '0;
    if (rst) begin
      m_busy = 0;
      m_starve = 0;
    end else if (m_busy) begin
      if (m_cyc == m_ret) begin
        if (m_own_if) begin e.if_rvalid = 1; e.if_rdata = m_data; end
        else begin e.dm_rvalid = 1; e.dm_rdata = m_data; end
        m_busy = 0;
      end
    end else begin
      iw = if_req && (!dm_req || m_starve == SMAX);
      dw = dm_req && !iw;
      if (iw) begin
        e.mem_en = 1; e.mem_addr = if_addr; e.if_ready = 1;
        m_data = sh_read(if_addr);
      end else if (dw) begin
        e.mem_en = 1; e.mem_we = dm_we; e.mem_addr = dm_addr; e.mem_wdata = dm_wdata;
        e.dm_ready = 1;
        if (dm_we) begin
          m_data = '0;
          sh_mem[dm_addr[7:2]] = dm_wdata;
          sh_wr[dm_addr[7:2]] = 1;
        end else begin
          m_data = sh_read(dm_addr);
        end
      end
      if (iw || dw) begin
        m_busy = 1; m_own_if = iw; m_ret = m_cyc + LAT;
      end
      if (dw && if_req) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
      else m_starve = 0;
    end
    e.stall_if  = if_req && !e.if_rvalid;
    e.stall_mem = dm_req && !e.dm_rvalid;
    m_cyc++;
  endtask

  task automatic cycle(input logic r, ir, input logic [31:0] ia,
                       input logic dr, dwe, input logic [31:0] da, dwd,
                       output outs_t e);
    @(negedge clk);
    rst = r; if_req = ir; if_addr = ia; dm_req = dr; dm_we = dwe; dm_addr = da; dm_wdata = dwd;
    #1;
    assert (r || !(if_wait && !ir)) else $error("protocol: if_req dropped before if_ready");
    assert (r || !(dm_wait && !dr)) else $error("protocol: dm_req dropped before dm_ready");
    model_step(e);
    check_outs("model", act_outs(), e);
    if_wait = ir && !r && !e.if_ready && !e.if_rvalid && !if_acc;
    dm_wait = dr && !r && !e.dm_ready && !e.dm_rvalid && !dm_acc;
    if (e.if_ready) if_acc = 1;
    if (e.if_rvalid || r) if_acc = 0;
    if (e.dm_ready) dm_acc = 1;
    if (e.dm_rvalid || r) dm_acc = 0;
  endtask

  task automatic agent_cycle(input logic r, output outs_t e);
    if (r) begin ip = 0; dp = 0; end
    cycle(r, ip, ia_a, dp, dwe_a, da_a, dwd_a, e);
    if (e.if_rvalid) ip = 0;
    if (e.dm_rvalid) dp = 0;
  endtask

  task automatic drain();
    outs_t e;
    for (int k = 0; k < 20 && (ip || dp); k++) agent_cycle(1'b0, e);
    if (ip || dp) check_int("drain_timeout", 1, 0);
    agent_cycle(1'b0, e);
  endtask

  vec_t tbl [17];

  initial begin : main
    outs_t e;
    int    grants [6];
    int    ng, iss, rv, cnt, np;
    int    pulses [4];
    logic [31:0] got;

    for (int i = 0; i < 64; i++) sh_wr[i] = 0;

    tbl[0]  = mkv(1,0,32'h0, 0,0,32'h0,32'h0, o(0,0,0,0, 0,0,0, 0,0,0, 0,0));
    tbl[1]  = mkv(0,1,32'h10,0,0,32'h0,32'h0, o(1,0,32'h10,0, 1,0,0, 0,0,0, 1,0));
    tbl[2]  = mkv(0,1,32'h10,0,0,32'h0,32'h0, o(0,0,0,0, 0,0,0, 0,0,0, 1,0));
    tbl[3]  = mkv(0,1,32'h10,0,0,32'h0,32'h0, o(0,0,0,0, 0,1,32'h00A00093, 0,0,0, 0,0));
    tbl[4]  = mkv(0,1,32'h14,1,0,32'h40,32'h0, o(1,0,32'h40,0, 0,0,0, 1,0,0, 1,1));
    tbl[5]  = mkv(0,1,32'h14,1,0,32'h40,32'h0, o(0,0,0,0, 0,0,0, 0,0,0, 1,1));
    tbl[6]  = mkv(0,1,32'h14,1,0,32'h40,32'h0, o(0,0,0,0, 0,0,0, 0,1,32'h10000040, 1,0));
    tbl[7]  = mkv(0,1,32'h14,0,0,32'h0,32'h0, o(1,0,32'h14,0, 1,0,0, 0,0,0, 1,0));
    tbl[8]  = mkv(0,1,32'h14,0,0,32'h0,32'h0, o(0,0,0,0, 0,0,0, 0,0,0, 1,0));
    tbl[9]  = mkv(0,1,32'h14,0,0,32'h0,32'h0, o(0,0,0,0, 0,1,32'h00B00113, 0,0,0, 0,0));
    tbl[10] = mkv(0,0,32'h0,1,1,32'h80,32'hDEADBEEF, o(1,1,32'h80,32'hDEADBEEF, 0,0,0, 1,0,0, 0,1));
    tbl[11] = mkv(0,0,32'h0,1,1,32'h80,32'hDEADBEEF, o(0,0,0,0, 0,0,0, 0,0,0, 0,1));
    tbl[12] = mkv(0,0,32'h0,1,1,32'h80,32'hDEADBEEF, o(0,0,0,0, 0,0,0, 0,1,0, 0,0));
    tbl[13] = mkv(0,0,32'h0,1,0,32'h80,32'h0, o(1,0,32'h80,0, 0,0,0, 1,0,0, 0,1));
    tbl[14] = mkv(0,0,32'h0,1,0,32'h80,32'h0, o(0,0,0,0, 0,0,0, 0,0,0, 0,1));
    tbl[15] = mkv(0,0,32'h0,1,0,32'h80,32'h0, o(0,0,0,0, 0,0,0, 0,1,32'hDEADBEEF, 0,0));
    tbl[16] = mkv(0,0,32'h0,0,0,32'h0,32'h0, o(0,0,0,0, 0,0,0, 0,0,0, 0,0));

    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].r, tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dwe, tbl[i].da, tbl[i].dwd, e);
      check_outs($sformatf("vec%0d", i), act_outs(), tbl[i].exp);
    end

    // Starvation: both ports request continuously.
    ng = 0;
    for (int k = 0; k < 40 && ng < 6; k++) begin
      if (!ip) begin ip = 1; ia_a = 32'h20 + 32'(4 * k); end
      if (!dp) begin dp = 1; dwe_a = 0; da_a = 32'h44 + 32'(4 * k); end
      agent_cycle(1'b0, e);
      if (if_ready || dm_ready) begin
        grants[ng] = if_ready ? 1 : 0;
        ng++;
      end
    end
    check_int("starve_grant_count", ng, 6);
    for (int g = 0; g < 6; g++)
      if (g < ng) check_int($sformatf("starve_grant%0d_is_if", g), grants[g], (g == 4) ? 1 : 0);
    drain();

    // Reset one cycle after a fetch issue.
    ip = 1; ia_a = 32'h10;
    agent_cycle(1'b0, e);
    check_int("rst_fetch_issued", int'(if_ready), 1);
    agent_cycle(1'b1, e);
    agent_cycle(1'b0, e);
    check_outs("post_rst_zero", act_outs(), '0);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      agent_cycle(1'b0, e);
      if (if_rvalid) cnt++;
    end
    check_int("rst_no_rvalid", cnt, 0);
    ip = 1; ia_a = 32'h14; iss = -1; rv = -1; got = '0;
    for (int k = 0; k < 12 && rv < 0; k++) begin
      agent_cycle(1'b0, e);
      if (if_ready && iss < 0) iss = k;
      if (if_rvalid) begin rv = k; got = if_rdata; end
    end
    check_int("rst_refetch_lat", rv - iss, LAT);
    check_int("rst_refetch_data", int'(got), int'(32'h00B00113));
    drain();

    // Back-to-back fetches.
    np = 0;
    for (int k = 0; k < 30 && np < 4; k++) begin
      if (!ip) begin ip = 1; ia_a = 32'h30 + 32'(4 * k); end
      agent_cycle(1'b0, e);
      check_int("b2b_ready_exclusive", int'(if_ready & dm_ready), 0);
      if (mem_en) begin pulses[np] = k; np++; end
    end
    check_int("b2b_pulse_count", np, 4);
    for (int p = 1; p < 4; p++)
      if (p < np) check_int($sformatf("b2b_spacing%0d", p), pulses[p] - pulses[p-1], LAT + 1);
    drain();

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      logic r;
      r = ($urandom_range(0, 199) == 0);
      if (!r) begin
        if (!ip && $urandom_range(0, 2) == 0) begin
          ip = 1; ia_a = 32'($urandom_range(0, 63)) << 2;
        end
        if (!dp && $urandom_range(0, 2) == 0) begin
          dp = 1; dwe_a = $urandom_range(0, 1) == 1;
          da_a = 32'($urandom_range(0, 63)) << 2; dwd_a = $urandom;
        end
      end
      agent_cycle(r, e);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
